// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS32 front end: datapath width, the NOP
//   encoding used for pipeline bubbles, bit positions inside the ID-stage
//   jump vector and the fetch FSM state type.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int XLEN = 32;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // jump[JMP_J]  : J/JAL, target from jump_target
    // jump[JMP_JR] : JR,    target from jr_target
    localparam int JMP_J  = 0;
    localparam int JMP_JR = 1;

    // FETCH : normal operation, one access in flight at imem_addr
    // DRAIN : a redirect arrived while the access was still outstanding;
    //         wait for it to retire before moving the PC
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage : mips_pkg

// File: rtl/next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
//   Combinational redirect decode for the IF stage. Turns the ID-stage
//   branch/jump controls into a single redirect flag and a word-aligned
//   target address.
//
//   Ports
//     i_branch        ID holds a conditional branch
//     i_branch_yes    branch condition resolved true
//     i_jump[1:0]     [JMP_J]=J/JAL, [JMP_JR]=JR
//     i_branch_target PC+4+(simm<<2)
//     i_jump_target   {PC+4[31:28], imm26, 2'b00}
//     i_jr_target     rs value
//     o_redirect      the PC must leave the sequential path
//     o_target        selected target with bits [1:0] cleared
// ---------------------------------------------------------------------------
module next_pc_sel
    import mips_pkg::*;
(
    input  logic            i_branch,
    input  logic            i_branch_yes,
    input  logic [1:0]      i_jump,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic [XLEN-1:0] i_jump_target,
    input  logic [XLEN-1:0] i_jr_target,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_target
);

    logic [XLEN-1:0] w_raw_target;

    assign o_redirect = (i_branch & i_branch_yes) | i_jump[JMP_J] | i_jump[JMP_JR];

    // JR wins over J/JAL, which wins over a taken branch. Only one should be
    // active at a time in a well-formed ID stage; the priority just makes the
    // choice deterministic.
    assign w_raw_target = i_jump[JMP_JR] ? i_jr_target   :
                          i_jump[JMP_J]  ? i_jump_target :
                                           i_branch_target;

    // A misaligned rs value in JR must not produce a misaligned fetch.
    assign o_target = {w_raw_target[XLEN-1:2], 2'b00};

endmodule : next_pc_sel

// File: rtl/fetch_ifid_stage.sv
// ---------------------------------------------------------------------------
// fetch_ifid_stage
//   IF stage plus IF/ID pipeline register of the 5-stage MIPS32 core.
//   Holds the PC, issues instruction-memory requests, applies the load-use
//   hold and the branch/jump redirect coming back from ID, and presents the
//   fetched word and PC+4 to ID.
//
//   Ports
//     clk, rst_n       core clock (rising edge), async active-low reset
//     hold             load-use stall: freezes PC, IF/ID, FSM, saved target
//     branch/branch_yes/jump/branch_target/jump_target/jr_target
//                      redirect controls computed in ID
//     imem_req/imem_addr/imem_valid/imem_rdata
//                      instruction memory port (see handshake note below)
//     if_id_instr/if_id_pc4/if_id_valid
//                      IF/ID register contents (valid=0 marks a bubble)
//     fetch_busy       request outstanding without data this cycle
//     dbg_state        current fetch FSM state, for debug and checkers
//
//   Instruction memory handshake:
//     imem_req is high whenever the block is out of reset and imem_addr
//     always equals the PC. The PC only changes in a cycle in which
//     imem_valid is high (or under reset), so imem_addr is stable for the
//     whole time a request waits for data. imem_valid=1 means imem_rdata is
//     the word at imem_addr in that same cycle; the access retires on that
//     edge even if the word is discarded (hold, redirect, or DRAIN).
// ---------------------------------------------------------------------------
module fetch_ifid_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               branch,
    input  logic               branch_yes,
    input  logic [1:0]         jump,
    input  logic [XLEN-1:0]    branch_target,
    input  logic [XLEN-1:0]    jump_target,
    input  logic [XLEN-1:0]    jr_target,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    if_id_instr,
    output logic [XLEN-1:0]    if_id_pc4,
    output logic               if_id_valid,
    output logic               fetch_busy,
    output fetch_state_t       dbg_state
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_saved_tgt;
    logic [XLEN-1:0] r_if_id_instr;
    logic [XLEN-1:0] r_if_id_pc4;
    logic            r_if_id_valid;
    fetch_state_t    r_state;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc4;

    next_pc_sel u_next_pc_sel (
        .i_branch        (branch),
        .i_branch_yes    (branch_yes),
        .i_jump          (jump),
        .i_branch_target (branch_target),
        .i_jump_target   (jump_target),
        .i_jr_target     (jr_target),
        .o_redirect      (w_redirect),
        .o_target        (w_target)
    );

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign w_pc4 = r_pc + 32'd4;

    // Request follows reset directly so it drops the instant rst_n falls.
    assign imem_req   = rst_n;
    assign imem_addr  = r_pc;
    assign fetch_busy = imem_req & ~imem_valid;

    assign if_id_instr = r_if_id_instr;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_valid = r_if_id_valid;
    assign dbg_state   = r_state;

    // hold gates everything, including redirect: ID will present the same
    // branch/jump again once the stall clears. Any word returned under hold
    // is dropped and the same PC is fetched again.
    //
    // A bubble clears instr/valid but leaves pc4 as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_saved_tgt   <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
            r_state       <= FETCH;
        end else if (!hold) begin
            case (r_state)
                FETCH: begin
                    if (imem_valid && !w_redirect) begin
                        r_if_id_instr <= imem_rdata;
                        r_if_id_pc4   <= w_pc4;
                        r_if_id_valid <= 1'b1;
                        r_pc          <= w_pc4;
                    end else begin
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                        if (w_redirect) begin
                            if (imem_valid) begin
                                // Access retires now; the word is on the wrong path.
                                r_pc <= w_target;
                            end else begin
                                // Access still in flight: keep imem_addr stable
                                // and park the target until it retires.
                                r_saved_tgt <= w_target;
                                r_state     <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    r_if_id_instr <= NOP_INSTR;
                    r_if_id_valid <= 1'b0;
                    if (imem_valid) begin
                        // The most recent redirect is the one that counts.
                        r_pc    <= w_redirect ? w_target : r_saved_tgt;
                        r_state <= FETCH;
                    end else if (w_redirect) begin
                        r_saved_tgt <= w_target;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule : fetch_ifid_stage
